// File: rtl/rfphoenix_mem_req_issuer_pkg.sv
// Shared memory-request types for the rfPhoenix load/store path.
// fnSel is also used by the request queue to compute byte-lane masks.
package rfphoenix_mem_req_issuer_pkg;

    typedef enum logic [1:0] {MR_LOAD, MR_LOADZ, MR_STORE} mem_func_t;
    typedef enum logic [1:0] {byt, wyde, tetra, octa} mem_sz_t;
    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, DONE} issuer_state_t;

    typedef struct packed {
        logic        v;
        logic [7:0]  tid;
        logic [3:0]  thread;
        logic [5:0]  tgt;
        mem_func_t   func;
        mem_sz_t     sz;
        logic [31:0] adr;
        logic [63:0] dat;
    } MemoryRequest;

    function automatic logic [15:0] fnSel(input mem_sz_t sz);
        case (sz)
            byt:     return 16'h0001;
            wyde:    return 16'h0003;
            tetra:   return 16'h000F;
            default: return 16'h00FF;
        endcase
    endfunction

endpackage

// File: rtl/rfphoenix_mem_req_issuer_if.sv
// Queue-head, Wishbone-classic bus and completion signals of the request issuer.
interface rfphoenix_mem_req_issuer_if
    import rfphoenix_mem_req_issuer_pkg::*;
#(
    parameter int AWID = 32
);
    logic            q_valid;
    MemoryRequest    q_req;
    logic            q_rd;
    logic            cyc_o;
    logic            stb_o;
    logic            we_o;
    logic [15:0]     sel_o;
    logic [AWID-1:0] adr_o;
    logic [127:0]    dat_o;
    logic            ack_i;
    logic            err_i;
    logic [127:0]    dat_i;
    logic            rollback;
    logic [3:0]      rollback_thread;
    logic            resp_valid;
    MemoryRequest    resp;
    logic            resp_err;
    logic            busy;

    modport master (
        input  q_valid, q_req, ack_i, err_i, dat_i, rollback, rollback_thread,
        output q_rd, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        output resp_valid, resp, resp_err, busy
    );

    modport slave (
        output q_valid, q_req, ack_i, err_i, dat_i, rollback, rollback_thread,
        input  q_rd, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        input  resp_valid, resp, resp_err, busy
    );

endinterface

// File: rtl/rfphoenix_mem_req_issuer_load_align.sv
// Extracts a load result from the two captured bus beats and extends it to 64 bits.
module rfphoenix_load_align
    import rfphoenix_mem_req_issuer_pkg::*;
(
    input  logic [255:0] beats,
    input  logic [3:0]   ofs,
    input  mem_func_t    func,
    input  mem_sz_t      sz,
    output logic [63:0]  result
);

    function automatic logic [63:0] fn_extend(input logic [63:0] raw, input mem_sz_t s,
                                              input logic zext);
        case (s)
            byt:     return zext ? {56'b0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            wyde:    return zext ? {48'b0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            tetra:   return zext ? {32'b0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: return raw;
        endcase
    endfunction

    logic [63:0] raw;

    assign raw    = 64'(beats >> {ofs, 3'b0});
    assign result = fn_extend(raw, sz, func == MR_LOADZ);

endmodule

// File: rtl/rfphoenix_mem_req_issuer.sv
// Drains the memory request queue one entry at a time as classic bus cycles,
// splitting line-crossing accesses into two beats, and reports completions.
module rfphoenix_mem_req_issuer
    import rfphoenix_mem_req_issuer_pkg::*;
#(
    parameter int AWID     = 32,
    parameter int TMO_BITS = 8
) (
    input logic clk,
    input logic rst_n,
    rfphoenix_mem_req_issuer_if.master bus
);

    issuer_state_t       state, state_nxt;
    logic                cyc_q, cyc_n, stb_q, stb_n, we_q, we_n;
    logic                kill_q, kill_n, err_q, err_n;
    logic [15:0]         sel_q, sel_n;
    logic [AWID-1:0]     adr_q, adr_n;
    logic [127:0]        dat_q, dat_n, dat_hi_q, dat_hi_n;
    logic [TMO_BITS-1:0] tmo_q, tmo_n, tmo_inc;
    MemoryRequest        req_q, req_n, resp_c;
    logic [127:0]        beat1_q, beat1_n, beat2_q, beat2_n;
    logic [15:0]         pop_sel;
    logic [255:0]        pop_dat;
    logic [31:0]         lat_sel;
    logic                bus_ack, bus_err, kill_now, q_rd_c;
    logic [63:0]         load_dat;

    assign pop_sel  = fnSel(bus.q_req.sz) << bus.q_req.adr[3:0];
    assign pop_dat  = {192'b0, bus.q_req.dat} << {bus.q_req.adr[3:0], 3'b0};
    assign lat_sel  = {16'b0, fnSel(req_q.sz)} << req_q.adr[3:0];
    // err_i dominates ack_i; neither counts unless the strobe is up
    assign bus_err  = stb_q && bus.err_i;
    assign bus_ack  = stb_q && bus.ack_i && !bus.err_i;
    assign kill_now = bus.rollback && (bus.rollback_thread == req_q.thread);
    assign tmo_inc  = tmo_q + TMO_BITS'(1);

    always_comb begin
        state_nxt = state;
        cyc_n     = cyc_q;
        stb_n     = stb_q;
        we_n      = we_q;
        sel_n     = sel_q;
        adr_n     = adr_q;
        dat_n     = dat_q;
        dat_hi_n  = dat_hi_q;
        tmo_n     = tmo_q;
        kill_n    = kill_q;
        err_n     = err_q;
        req_n     = req_q;
        beat1_n   = beat1_q;
        beat2_n   = beat2_q;
        q_rd_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.q_valid) begin
                    q_rd_c = 1'b1;
                    req_n  = bus.q_req;
                    if (bus.q_req.v) begin
                        state_nxt = BEAT1;
                        cyc_n     = 1'b1;
                        stb_n     = 1'b1;
                        we_n      = (bus.q_req.func == MR_STORE);
                        adr_n     = {bus.q_req.adr[AWID-1:4], 4'h0};
                        sel_n     = pop_sel;
                        dat_n     = pop_dat[127:0];
                        dat_hi_n  = pop_dat[255:128];
                        tmo_n     = '0;
                        err_n     = 1'b0;
                        kill_n    = bus.rollback && (bus.rollback_thread == bus.q_req.thread);
                    end
                end
            end
            BEAT1, BEAT2: begin
                if (kill_now)
                    kill_n = 1'b1;
                if (!stb_q) begin
                    stb_n = 1'b1;
                end else if (bus_err) begin
                    state_nxt = DONE;
                    {cyc_n, stb_n, we_n} = 3'b000;
                    sel_n     = '0;
                    err_n     = 1'b1;
                end else if (bus_ack) begin
                    if (state == BEAT1)
                        beat1_n = bus.dat_i;
                    else
                        beat2_n = bus.dat_i;
                    // Line crossing: hold cyc_o, drop stb_o for one cycle, then the upper line
                    if (state == BEAT1 && lat_sel[31:16] != 16'h0) begin
                        state_nxt = BEAT2;
                        stb_n     = 1'b0;
                        adr_n     = adr_q + AWID'(16);
                        sel_n     = lat_sel[31:16];
                        dat_n     = dat_hi_q;
                        tmo_n     = '0;
                    end else begin
                        state_nxt = DONE;
                        {cyc_n, stb_n, we_n} = 3'b000;
                        sel_n     = '0;
                    end
                end else begin
                    tmo_n = tmo_inc;
                    if (tmo_inc == '1) begin
                        state_nxt = DONE;
                        {cyc_n, stb_n, we_n} = 3'b000;
                        sel_n     = '0;
                        err_n     = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            adr_q  <= '0;
            dat_q  <= '0;
            tmo_q  <= '0;
            kill_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cyc_q  <= cyc_n;
            stb_q  <= stb_n;
            we_q   <= we_n;
            sel_q  <= sel_n;
            adr_q  <= adr_n;
            dat_q  <= dat_n;
            tmo_q  <= tmo_n;
            kill_q <= kill_n;
            err_q  <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        req_q    <= req_n;
        beat1_q  <= beat1_n;
        beat2_q  <= beat2_n;
        dat_hi_q <= dat_hi_n;
    end

    rfphoenix_load_align u_align (
        .beats  ({beat2_q, beat1_q}),
        .ofs    (req_q.adr[3:0]),
        .func   (req_q.func),
        .sz     (req_q.sz),
        .result (load_dat)
    );

    always_comb begin
        resp_c = '0;
        if (state == DONE) begin
            resp_c     = req_q;
            resp_c.dat = (req_q.func == MR_STORE || err_q) ? 64'h0 : load_dat;
        end
    end

    assign bus.q_rd       = q_rd_c;
    assign bus.cyc_o      = cyc_q;
    assign bus.stb_o      = stb_q;
    assign bus.we_o       = we_q;
    assign bus.sel_o      = sel_q;
    assign bus.adr_o      = adr_q;
    assign bus.dat_o      = dat_q;
    assign bus.busy       = (state != IDLE);
    assign bus.resp_valid = (state == DONE) && !kill_q && !kill_now;
    assign bus.resp_err   = bus.resp_valid && err_q;
    assign bus.resp       = resp_c;

endmodule

// File: tb/tb_rfphoenix_mem_req_issuer.sv
// Directed bench for the memory request issuer.
module tb_rfphoenix_mem_req_issuer;
    import rfphoenix_mem_req_issuer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rfphoenix_mem_req_issuer_if #(.AWID(32)) bif ();

    rfphoenix_mem_req_issuer #(.AWID(32), .TMO_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    function automatic MemoryRequest mk_req(input logic v, input logic [3:0] th,
                                            input mem_func_t f, input mem_sz_t s,
                                            input logic [31:0] a, input logic [63:0] d);
        MemoryRequest r;
        r        = '0;
        r.v      = v;
        r.tid    = 8'h5A;
        r.thread = th;
        r.tgt    = 6'h11;
        r.func   = f;
        r.sz     = s;
        r.adr    = a;
        r.dat    = d;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bif.q_valid         = 1'b0;
        bif.q_req           = '0;
        bif.ack_i           = 1'b0;
        bif.err_i           = 1'b0;
        bif.dat_i           = '0;
        bif.rollback        = 1'b0;
        bif.rollback_thread = 4'h0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        checks++;
        if ({bif.cyc_o, bif.stb_o, bif.we_o, bif.resp_valid, bif.resp_err, bif.busy, bif.q_rd} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000000",
                     {bif.cyc_o, bif.stb_o, bif.we_o, bif.resp_valid, bif.resp_err, bif.busy, bif.q_rd});
        end
        checks++;
        if (bif.sel_o !== 16'h0 || bif.adr_o !== 32'h0 || bif.dat_o !== 128'h0) begin
            failures++;
            $display("FAIL reset_bus sel=%h adr=%h dat=%h exp=0", bif.sel_o, bif.adr_o, bif.dat_o);
        end
        checks++;
        if (bif.resp !== '0) begin
            failures++;
            $display("FAIL reset_resp got=%h exp=0", bif.resp);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_byt;
        logic [127:0] d;
        d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        d[31:24] = 8'h80;
        tick();
        bif.q_valid = 1'b1;
        bif.q_req   = mk_req(1'b1, 4'h1, MR_LOAD, byt, 32'h1003, 64'h0);
        #1;
        checks++;
        if (bif.q_rd !== 1'b1) begin
            failures++;
            $display("FAIL byt_q_rd got=%b exp=1", bif.q_rd);
        end
        tick();
        bif.q_valid = 1'b0;
        bif.ack_i   = 1'b1;
        bif.dat_i   = d;
        #1;
        checks++;
        if ({bif.cyc_o, bif.stb_o, bif.we_o} !== 3'b110) begin
            failures++;
            $display("FAIL byt_cyc_stb_we got=%b exp=110", {bif.cyc_o, bif.stb_o, bif.we_o});
        end
        checks++;
        if (bif.sel_o !== 16'h0008 || bif.adr_o !== 32'h1000) begin
            failures++;
            $display("FAIL byt_sel_adr got=%h/%h exp=0008/00001000", bif.sel_o, bif.adr_o);
        end
        tick();
        bif.ack_i = 1'b0;
        #1;
        checks++;
        if (bif.resp_valid !== 1'b1 || bif.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL byt_resp_valid got=%b err=%b exp=1 err=0", bif.resp_valid, bif.resp_err);
        end
        checks++;
        if (bif.resp.dat !== 64'hFFFF_FFFF_FFFF_FF80) begin
            failures++;
            $display("FAIL byt_resp_dat got=%h exp=ffffffffffffff80", bif.resp.dat);
        end
        checks++;
        if (bif.resp.tid !== 8'h5A || bif.resp.thread !== 4'h1 || bif.resp.tgt !== 6'h11) begin
            failures++;
            $display("FAIL byt_resp_ids got=%h/%h/%h exp=5a/1/11", bif.resp.tid, bif.resp.thread, bif.resp.tgt);
        end
        tick();
        #1;
        checks++;
        if (bif.resp_valid !== 1'b0 || bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL byt_after got=%b/%b exp=0/0", bif.resp_valid, bif.busy);
        end
    endtask

    task automatic test_loadz_octa;
        tick();
        bif.q_valid = 1'b1;
        bif.q_req   = mk_req(1'b1, 4'h3, MR_LOADZ, octa, 32'h200C, 64'h0);
        #1;
        tick();
        bif.q_valid = 1'b0;
        bif.ack_i   = 1'b1;
        bif.dat_i   = 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4;
        #1;
        checks++;
        if (bif.sel_o !== 16'hF000 || bif.adr_o !== 32'h2000) begin
            failures++;
            $display("FAIL octa_beat1 got=%h/%h exp=f000/00002000", bif.sel_o, bif.adr_o);
        end
        tick();
        bif.ack_i = 1'b0;
        bif.dat_i = '0;
        #1;
        checks++;
        if ({bif.cyc_o, bif.stb_o} !== 2'b10 || bif.sel_o !== 16'h000F || bif.adr_o !== 32'h2010) begin
            failures++;
            $display("FAIL octa_gap got=%b %h/%h exp=10 000f/00002010", {bif.cyc_o, bif.stb_o}, bif.sel_o, bif.adr_o);
        end
        tick();
        bif.ack_i = 1'b1;
        bif.dat_i = 128'h11111111_22222222_33333333_89ABCDEF;
        #1;
        checks++;
        if ({bif.cyc_o, bif.stb_o} !== 2'b11) begin
            failures++;
            $display("FAIL octa_beat2 got=%b exp=11", {bif.cyc_o, bif.stb_o});
        end
        tick();
        bif.ack_i = 1'b0;
        #1;
        checks++;
        if (bif.resp_valid !== 1'b1 || bif.resp.dat !== 64'h89ABCDEF_A1A2A3A4) begin
            failures++;
            $display("FAIL octa_resp got=%b %h exp=1 89abcdefa1a2a3a4", bif.resp_valid, bif.resp.dat);
        end
        tick();
    endtask

    task automatic test_store;
        tick();
        bif.q_valid = 1'b1;
        bif.q_req   = mk_req(1'b1, 4'h1, MR_STORE, tetra, 32'h3004, 64'hDEADBEEF);
        #1;
        tick();
        bif.q_valid = 1'b0;
        bif.ack_i   = 1'b1;
        #1;
        checks++;
        if (bif.we_o !== 1'b1 || bif.sel_o !== 16'h00F0) begin
            failures++;
            $display("FAIL store_we_sel got=%b/%h exp=1/00f0", bif.we_o, bif.sel_o);
        end
        checks++;
        if (bif.dat_o !== 128'hDEADBEEF_00000000) begin
            failures++;
            $display("FAIL store_dat got=%h exp=deadbeef00000000", bif.dat_o);
        end
        tick();
        bif.ack_i = 1'b0;
        #1;
        checks++;
        if (bif.resp_valid !== 1'b1 || bif.resp.dat !== 64'h0) begin
            failures++;
            $display("FAIL store_resp got=%b %h exp=1 0", bif.resp_valid, bif.resp.dat);
        end
        tick();
    endtask

    task automatic test_timeout;
        int n;
        n = 0;
        tick();
        bif.q_valid = 1'b1;
        bif.q_req   = mk_req(1'b1, 4'h1, MR_LOAD, byt, 32'h4000, 64'h0);
        #1;
        tick();
        bif.q_valid = 1'b0;
        #1;
        while (bif.cyc_o === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        checks++;
        if (n != 255) begin
            failures++;
            $display("FAIL timeout_cycles got=%0d exp=255", n);
        end
        checks++;
        if (bif.resp_valid !== 1'b1 || bif.resp_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_resp got=%b/%b exp=1/1", bif.resp_valid, bif.resp_err);
        end
        tick();
    endtask

    task automatic test_err_wins;
        tick();
        bif.q_valid = 1'b1;
        bif.q_req   = mk_req(1'b1, 4'h6, MR_LOAD, wyde, 32'h6002, 64'h0);
        #1;
        tick();
        bif.q_valid = 1'b0;
        bif.ack_i   = 1'b1;
        bif.err_i   = 1'b1;
        bif.dat_i   = 128'hFFFF_FFFF;
        #1;
        tick();
        bif.ack_i = 1'b0;
        bif.err_i = 1'b0;
        #1;
        checks++;
        if (bif.resp_valid !== 1'b1 || bif.resp_err !== 1'b1) begin
            failures++;
            $display("FAIL err_wins got=%b/%b exp=1/1", bif.resp_valid, bif.resp_err);
        end
        checks++;
        if (bif.cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL err_cyc got=%b exp=0", bif.cyc_o);
        end
        tick();
    endtask

    task automatic test_rollback;
        tick();
        bif.q_valid = 1'b1;
        bif.q_req   = mk_req(1'b1, 4'h2, MR_LOAD, byt, 32'h5000, 64'h0);
        #1;
        tick();
        bif.q_valid         = 1'b0;
        bif.rollback        = 1'b1;
        bif.rollback_thread = 4'h2;
        #1;
        tick();
        bif.rollback = 1'b0;
        bif.ack_i    = 1'b1;
        #1;
        checks++;
        if (bif.cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL rb_cycle_runs got=%b exp=1", bif.cyc_o);
        end
        tick();
        bif.ack_i = 1'b0;
        #1;
        checks++;
        if (bif.resp_valid !== 1'b0 || bif.busy !== 1'b1) begin
            failures++;
            $display("FAIL rb_suppress got=%b busy=%b exp=0 busy=1", bif.resp_valid, bif.busy);
        end
        tick();
        // same-thread rollback coincident with the pop
        bif.q_valid         = 1'b1;
        bif.q_req           = mk_req(1'b1, 4'h4, MR_LOAD, byt, 32'h5000, 64'h0);
        bif.rollback        = 1'b1;
        bif.rollback_thread = 4'h4;
        #1;
        tick();
        bif.q_valid  = 1'b0;
        bif.rollback = 1'b0;
        bif.ack_i    = 1'b1;
        #1;
        tick();
        bif.ack_i = 1'b0;
        #1;
        checks++;
        if (bif.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rb_at_pop got=%b exp=0", bif.resp_valid);
        end
        tick();
        bif.q_valid = 1'b1;
        bif.q_req   = mk_req(1'b1, 4'h2, MR_LOAD, byt, 32'h5000, 64'h0);
        #1;
        tick();
        bif.q_valid         = 1'b0;
        bif.rollback        = 1'b1;
        bif.rollback_thread = 4'h5;
        bif.ack_i           = 1'b1;
        #1;
        tick();
        bif.rollback = 1'b0;
        bif.ack_i    = 1'b0;
        #1;
        checks++;
        if (bif.resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL rb_other_thread got=%b exp=1", bif.resp_valid);
        end
        tick();
    endtask

    task automatic test_discard;
        logic seen;
        seen = 1'b0;
        tick();
        bif.q_valid = 1'b1;
        bif.q_req   = mk_req(1'b0, 4'h2, MR_LOAD, byt, 32'h7000, 64'h0);
        #1;
        checks++;
        if (bif.q_rd !== 1'b1) begin
            failures++;
            $display("FAIL discard_q_rd got=%b exp=1", bif.q_rd);
        end
        tick();
        bif.q_valid = 1'b0;
        #1;
        checks++;
        if (bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL discard_busy got=%b exp=0", bif.busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (bif.cyc_o !== 1'b0 || bif.resp_valid !== 1'b0)
                seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL discard_no_cycle got=%b exp=0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int pops, resps, bad;
        pops = 0;
        resps = 0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) begin
                bif.q_valid = 1'b1;
                bif.q_req   = mk_req(1'b1, 4'h1, MR_LOAD, byt, 32'h1003, 64'h0);
                bif.ack_i   = 1'b1;
                bif.dat_i   = 128'h0;
            end
            #1;
            if (bif.q_rd === 1'b1) pops++;
            if (bif.resp_valid === 1'b1) resps++;
            if (bif.q_rd === 1'b1 && bif.busy !== 1'b0) bad++;
        end
        bif.q_valid = 1'b0;
        bif.ack_i   = 1'b0;
        checks++;
        if (pops != 2) begin
            failures++;
            $display("FAIL b2b_pops got=%0d exp=2", pops);
        end
        checks++;
        if (resps != 2) begin
            failures++;
            $display("FAIL b2b_resps got=%0d exp=2", resps);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL b2b_q_rd_busy got=%0d exp=0", bad);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        tick();
        bif.q_valid = 1'b1;
        bif.q_req   = mk_req(1'b1, 4'h3, MR_LOADZ, octa, 32'h200C, 64'h0);
        #1;
        tick();
        bif.q_valid = 1'b0;
        bif.ack_i   = 1'b1;
        #1;
        tick();
        bif.ack_i = 1'b0;
        #1;
        tick();
        #1;
        checks++;
        if ({bif.cyc_o, bif.stb_o} !== 2'b11) begin
            failures++;
            $display("FAIL rstmid_pre got=%b exp=11", {bif.cyc_o, bif.stb_o});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bif.cyc_o, bif.stb_o, bif.resp_valid, bif.busy} !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_async got=%b exp=0000", {bif.cyc_o, bif.stb_o, bif.resp_valid, bif.busy});
        end
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if (bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle got=%b exp=0", bif.busy);
        end
    endtask

    initial begin
        test_reset();
        test_load_byt();
        test_loadz_octa();
        test_store();
        test_timeout();
        test_err_wins();
        test_rollback();
        test_discard();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
